// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-bus master and the register set.
//   - REG_DATA_WIDTH / REG_ADDR_WIDTH : default word and address widths
//   - state_e                         : request FSM state encoding
package reg_bus_pkg;

  localparam int REG_DATA_WIDTH = 16;
  localparam int REG_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for an upstream command
    ST_REQ  = 2'd1,  // request driven to the responder, waiting for ack
    ST_RSP  = 2'd2   // response held for upstream
  } state_e;

endpackage

// File: rtl/timeout_counter.sv
// Cycle counter bounding how long a request may wait for an acknowledge.
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset, clears the count
//   clear   : return the count to 0
//   enable  : count one cycle (ignored while clear is high)
//   expired : high in the cycle the count reaches TIMEOUT_CYCLES-1 while enabled
// Parameter TIMEOUT_CYCLES : number of enabled cycles until expiry (1..65535).
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // The count saturates at LAST so a held enable can never wrap back to 0.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/reg_access_master.sv
// Register-bus master: turns one upstream command (read or write) into a
// req/ack handshake with a register responder and returns a single response,
// flagging an error when the responder does not ack within TIMEOUT_CYCLES.
// Ports:
//   clk, reset                          : clock and synchronous active-high reset
//   cmd_valid/cmd_ready                 : upstream command handshake
//   cmd_wnr, cmd_address, cmd_wdata     : command (0 read / 1 write), address, write data
//   rsp_valid/rsp_ready                 : upstream response handshake
//   rsp_rdata, rsp_error                : read data (0 for writes/errors), timeout flag
//   req, wnr, address, wr_data          : request to the responder
//   ack, rd_data                        : registered responder acknowledge and read data
module reg_access_master
  import reg_bus_pkg::*;
#(
  parameter int DATA_WIDTH     = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH     = REG_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wnr,
  input  logic [ADDR_WIDTH-1:0] cmd_address,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  req,
  output logic                  wnr,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  ack,
  input  logic [DATA_WIDTH-1:0] rd_data
);

  state_e                state_q, state_d;
  logic                  req_q, req_d;
  logic                  wnr_q, wnr_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;

  logic tmo_clear;
  logic tmo_enable;
  logic tmo_expired;
  logic cmd_accept;

  // The counter runs only while a request is outstanding and sits at 0 otherwise,
  // so every request starts counting from 0 in its first cycle.
  assign tmo_enable = (state_q == ST_REQ);
  assign tmo_clear  = (state_q != ST_REQ);

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  // A high ack while idle is a late ack from a timed-out request; holding off
  // new commands until it drops keeps it from being taken as the next ack.
  assign cmd_ready  = (state_q == ST_IDLE) && !ack && !reset;
  assign cmd_accept = cmd_valid && cmd_ready;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    wnr_d       = wnr_q;
    address_d   = address_q;
    wr_data_d   = wr_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          wnr_d     = cmd_wnr;
          address_d = cmd_address;
          wr_data_d = cmd_wdata;
          req_d     = 1'b1;
          state_d   = ST_REQ;
        end
      end

      ST_REQ: begin
        // req is registered: it stays high through the ack (or expiry) cycle
        // and drops in the cycle the response appears. Ack is checked first
        // so an ack in the expiry cycle still completes the access.
        if (ack) begin
          rsp_rdata_d = wnr_q ? '0 : rd_data;
          rsp_error_d = 1'b0;
          rsp_valid_d = 1'b1;
          req_d       = 1'b0;
          state_d     = ST_RSP;
        end else if (tmo_expired) begin
          rsp_rdata_d = '0;
          rsp_error_d = 1'b1;
          rsp_valid_d = 1'b1;
          req_d       = 1'b0;
          state_d     = ST_RSP;
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        req_d       = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      wnr_q       <= 1'b0;
      address_q   <= '0;
      wr_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      wnr_q       <= wnr_d;
      address_q   <= address_d;
      wr_data_q   <= wr_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign req       = req_q;
  assign wnr       = wnr_q;
  assign address   = address_q;
  assign wr_data   = wr_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_reg_access_master.sv
`timescale 1ns/1ps
module tb_reg_access_master;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int TMO   = 4;
  localparam int NEVER = -1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_wnr;
  logic [AW-1:0] cmd_address;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_error;
  logic [DW-1:0] rsp_rdata;
  logic          req, wnr, ack;
  logic [AW-1:0] address;
  logic [DW-1:0] wr_data, rd_data;

  reg_access_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wnr(cmd_wnr),
    .cmd_address(cmd_address), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .req(req), .wnr(wnr), .address(address), .wr_data(wr_data),
    .ack(ack), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic w; logic [AW-1:0] a; logic [DW-1:0] d; int acc; int len; } req_exp_t;
  typedef struct { logic [DW-1:0] rdata; logic err; int acc; int len; } rsp_exp_t;

  req_exp_t      req_exp_q[$];
  rsp_exp_t      rsp_exp_q[$];
  int            dly_q[$];
  logic [DW-1:0] model_mem [0:7];  // what the register set should contain
  logic [DW-1:0] dev_mem   [0:7];  // the responder's own storage
  int            checks = 0;
  int            errors = 0;
  int            rdy_mode = 0;     // 0 random, 1 hold low, 2 hold high

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Responder acks 2+dly cycles into the request (dly=0 is a one-cycle
  // responder); the master only hears it while req is still up, i.e. up to
  // the TMO-th request cycle.
  function automatic bit acked(input int dly);
    return (dly >= 0) && (dly + 2 <= TMO);
  endfunction

  function automatic int exp_len(input int dly);
    return acked(dly) ? dly + 2 : TMO;
  endfunction

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int dly, input bit expect_rsp, output int acc);
    bit       got;
    req_exp_t re;
    rsp_exp_t se;
    got = 0;
    acc = -1;
    cmd_valid = 1'b1; cmd_wnr = w; cmd_address = a; cmd_wdata = d;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1;
        acc = cyc;
        re.w = w; re.a = a; re.d = d; re.acc = cyc; re.len = exp_len(dly);
        req_exp_q.push_back(re);
        dly_q.push_back(dly);
        if (expect_rsp) begin
          se.err   = !acked(dly);
          se.rdata = (acked(dly) && !w) ? model_mem[a[2:0]] : '0;
          se.acc   = cyc;
          se.len   = exp_len(dly);
          rsp_exp_q.push_back(se);
        end
        // The register set stores a write whenever it acks, late or not.
        if (w && dly >= 0) model_mem[a[2:0]] = d;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("cmd_accepted", {31'd0, got}, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rsp_exp_q.size() != 0 || req || rsp_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", {31'd0, (n < 300)}, 32'd1);
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
  endtask

  // Registered responder: decides on the values of cycle c, drives ack in c+1.
  initial begin
    int            rem;
    int            dly;
    bit            active, seen, nack;
    logic          lw;
    logic [2:0]    la;
    logic [DW-1:0] ld, nrd;
    ack = 1'b0; rd_data = '0; active = 0; seen = 0; rem = 0; lw = 0; la = 0; ld = 0;
    forever begin
      @(negedge clk);
      nack = 0;
      nrd  = DW'($urandom);
      if (reset) begin
        active = 0;
        seen   = 0;
      end else begin
        if (active) begin
          if (rem == 0) begin
            nack = 1; active = 0;
          end else begin
            rem--;
          end
        end else if (req && !seen) begin
          seen = 1; lw = wnr; la = address[2:0]; ld = wr_data;
          dly = (dly_q.size() > 0) ? dly_q.pop_front() : NEVER;
          if (dly == 0) nack = 1;
          else if (dly > 0) begin active = 1; rem = dly - 1; end
        end
        if (!req) seen = 0;
        if (nack) begin
          if (lw) dev_mem[la] = ld;
          else    nrd = dev_mem[la];
        end
      end
      @(posedge clk); #1;
      ack = nack;
      rd_data = nrd;
    end
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       rsp_ready = ($urandom_range(0, 3) != 0);
        1:       rsp_ready = 1'b0;
        default: rsp_ready = 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit            prev_req, cont_rv, prev_ack;
    int            run;
    req_exp_t      cr;
    rsp_exp_t      se;
    logic [DW-1:0] prd;
    logic          pre;
    prev_req = 0; cont_rv = 0; prev_ack = 0; run = 0; prd = '0; pre = 0;
    cr = '{w: 1'b0, a: '0, d: '0, acc: 0, len: 0};
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 0; cont_rv = 0; prev_ack = 0; run = 0;
        continue;
      end
      if (ack) chk("no_accept_while_ack", {31'd0, cmd_ready}, 32'd0);
      if (!req && !rsp_valid) chk("idle_cmd_ready", {31'd0, cmd_ready}, {31'd0, !ack});
      if (req) begin
        chk("cmd_ready_in_req", {31'd0, cmd_ready}, 32'd0);
        if (!prev_req) begin
          if (req_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_unexpected: got req=1, expected no request (cycle %0d)", cyc);
          end else begin
            cr = req_exp_q.pop_front();
            chk("req_start_cycle", cyc, cr.acc + 1);
            chk("req_after_stale_ack", {31'd0, prev_ack}, 32'd0);
          end
          run = 1;
        end else begin
          run++;
        end
        chk("req_wnr", {31'd0, wnr}, {31'd0, cr.w});
        chk("req_address", {16'd0, address}, {16'd0, cr.a});
        chk("req_wr_data", {16'd0, wr_data}, {16'd0, cr.d});
      end else if (prev_req) begin
        chk("req_length", run, cr.len);
      end
      if (rsp_valid) begin
        chk("cmd_ready_in_rsp", {31'd0, cmd_ready}, 32'd0);
        if (!cont_rv) begin
          if (rsp_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected: got rsp_valid=1, expected no response (cycle %0d)", cyc);
          end else begin
            se = rsp_exp_q.pop_front();
            chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, se.rdata});
            chk("rsp_error", {31'd0, rsp_error}, {31'd0, se.err});
            chk("rsp_latency", cyc, se.acc + se.len + 1);
          end
        end else begin
          chk("rsp_rdata_stable", {16'd0, rsp_rdata}, {16'd0, prd});
          chk("rsp_error_stable", {31'd0, rsp_error}, {31'd0, pre});
        end
        prd = rsp_rdata;
        pre = rsp_error;
      end
      cont_rv  = rsp_valid && !rsp_ready;
      prev_req = req;
      prev_ack = ack;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected completion by 2 ms (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, n;
    logic w;
    int   r, dly;
    reset = 1'b1; cmd_valid = 1'b0; cmd_wnr = 1'b0; cmd_address = '0; cmd_wdata = '0;
    for (int i = 0; i < 8; i++) begin model_mem[i] = '0; dev_mem[i] = '0; end

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("reset_req", {31'd0, req}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // Write then read with a one-cycle responder, then timeout and the
    // ack-in-expiry-cycle tie.
    rdy_mode = 2;
    issue(1'b1, 16'h0003, 16'h1234, 0, 1'b1, acc1);
    issue(1'b0, 16'h0003, 16'h0000, 0, 1'b1, acc1);
    issue(1'b1, 16'h0002, 16'hBEEF, NEVER, 1'b1, acc1);
    issue(1'b0, 16'h0002, 16'h0000, TMO - 2, 1'b1, acc1);
    drain();

    // Upstream stalls the response.
    rdy_mode = 1;
    issue(1'b0, 16'h0003, 16'h0000, 1, 1'b1, acc1);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("stall_rsp_seen", {31'd0, rsp_valid}, 32'd1);
    repeat (5) @(negedge clk);
    chk("stall_rsp_held", {31'd0, rsp_valid}, 32'd1);
    rdy_mode = 2;
    drain();

    // Late ack after timeout, next command already waiting.
    issue(1'b1, 16'h0001, 16'hA5A5, TMO, 1'b1, acc1);
    issue(1'b0, 16'h0001, 16'h0000, 0, 1'b1, acc2);
    chk("late_ack_accept_cycle", acc2, acc1 + TMO + 3);
    drain();

    // Randomized traffic.
    rdy_mode = 0;
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 9);
      case (r)
        4:       dly = 1;
        5, 9:    dly = 2;
        6:       dly = 3;
        7:       dly = 4;
        8:       dly = NEVER;
        default: dly = 0;
      endcase
      w = 1'($urandom_range(0, 1));
      issue(w, AW'($urandom_range(0, 7)), DW'($urandom), dly, 1'b1, acc1);
    end
    drain();

    // Reset in the middle of a request: no response may follow.
    rdy_mode = 2;
    issue(1'b1, 16'h0005, 16'h5A5A, NEVER, 1'b0, acc1);
    n = 0;
    while (!req && n < 20) begin @(negedge clk); n++; end
    chk("abort_req_seen", {31'd0, req}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_cmd_ready_in_reset", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_req", {31'd0, req}, 32'd0);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_wnr", {31'd0, wnr}, 32'd0);
    chk("abort_address", {16'd0, address}, 32'd0);
    chk("abort_wr_data", {16'd0, wr_data}, 32'd0);
    chk("abort_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("abort_rsp_error", {31'd0, rsp_error}, 32'd0);
    chk("abort_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    issue(1'b0, 16'h0005, 16'h0000, 0, 1'b1, acc1);
    issue(1'b0, 16'h0003, 16'h0000, 1, 1'b1, acc1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
